mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single external memory port between instruction fetch (IF) and data access (MEM).
- Runs a multi-cycle bus handshake and raises stall requests toward the pipeline stall controller.
- Discards an in-flight instruction fetch when EX resolves a taken branch or jump (flush), so the ID/EX-side flush logic never sees a stale instruction.
- Sits between the IF/MEM stages and the memory bus.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width; the write mask is DATA_W/8 bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address; stable while if_req is high
- if_data  out  DATA_W  fetched instruction; valid while if_done is high
- if_done  out  1  one-cycle pulse: fetch complete
- mem_req  in  1  data request; held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_wmask  in  DATA_W/8  byte enables for a store
- mem_rdata  out  DATA_W  load data; valid while mem_done is high
- mem_done  out  1  one-cycle pulse: data access complete
- flush  in  1  taken branch/jump from EX (ex_b_flag)
- stallreq_if  out  1  = if_req & ~if_done (combinational)
- stallreq_mem  out  1  = mem_req & ~mem_done (combinational)
- bus_req  out  1  bus transaction valid
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_wmask  out  DATA_W/8  bus byte enables
- bus_rdata  in  DATA_W  bus read data; valid with bus_ack
- bus_ack  in  1  bus completes the current transaction

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - State = IDLE, drop = 0.
  - All registered outputs are 0: bus_*, if_data, if_done, mem_rdata, mem_done.
  - Any in-flight bus transaction is abandoned; the bus shares the same rst.
- FSM states: IDLE, IF_BUSY, MEM_BUSY.
- IDLE:
  - A requester is eligible when its req = 1 and its done = 0 in the current cycle. This stops a request that is being retired from being re-issued.
  - MEM has fixed priority: mem eligible -> MEM_BUSY; else if eligible -> IF_BUSY; else stay.
  - On the transition edge, the bus outputs are registered from the winner and bus_req = 1.
  - For IF: bus_we = 0, bus_wmask = 0.
- IF_BUSY / MEM_BUSY:
  - bus_* are held stable until bus_ack.
  - On the bus_ack edge: bus_req <= 0; next state IDLE.
  - MEM: mem_rdata <= bus_rdata and mem_done <= 1 for one cycle. Stores also pulse mem_done; mem_rdata then = bus_rdata, don't-care.
  - IF, with drop = 0 and flush = 0: if_data <= bus_rdata, if_done <= 1 for one cycle.
- Latency: request seen at edge N; bus_req high after N; ack sampled at edge M >= N+1; done high during cycle M+1. Minimum request-to-done latency is 2 cycles.
- Flush rules:
  - flush in IF_BUSY without bus_ack: drop <= 1.
  - flush in IF_BUSY with bus_ack: the result is discarded; no if_done.
  - bus_ack in IF_BUSY with drop = 1: the result is discarded, drop <= 0, no if_done.
  - flush in IDLE or MEM_BUSY: no effect. The MEM instruction is older than the branch and always completes.
  - A discarded fetch leaves stallreq_if high while if_req stays high. IF then re-requests with the new PC, which is issued from IDLE.
- Simultaneous mem_req and if_req: MEM is served first, IF next. The IF stall persists across both transactions.
- No outstanding pipelining: at most one bus transaction in flight.
- if_done and mem_done are never high in the same cycle.

Decomposition:
- Shared header (alongside Defines.vh):
  - arbiter state encodings (ARB_IDLE, ARB_IF, ARB_MEM)
  - ADDR_W/DATA_W defaults tied to InstAddrBus/RegBus
  - the byte-mask width macro
- Flat module; no sub-module is natural at this size.

Test Plan:
- Single fetch:
  - Stimulus: if_req = 1, if_addr = 0x100; bus acks 1 cycle after bus_req with 0x00A00093.
  - Response: bus_addr = 0x100; if_done pulses once with if_data = 0x00A00093; stallreq_if drops in the done cycle; no re-issue.
- Contention:
  - Stimulus: if_req (0x104) and mem_req load (0x2000) raised in the same cycle; ack latency 3.
  - Response: the MEM transaction is on the bus first; mem_done then IF issue; stallreq_if stays high throughout.
- Store:
  - Stimulus: mem_we = 1, addr = 0x2004, wdata = 0xDEADBEEF, wmask = 0x3.
  - Response: bus_we = 1, bus_wmask = 0x3, fields held stable until ack; mem_done pulses once.
- Flush mid-fetch:
  - Stimulus: fetch 0x108 in IF_BUSY; flush pulses 2 cycles before ack.
  - Response: no if_done; the next if_req at 0x200 is issued and returns normally.
- Flush on ack cycle:
  - Stimulus: flush coincides with bus_ack.
  - Response: result discarded, drop stays 0, the following fetch completes.
  - Stimulus: flush during MEM_BUSY.
  - Response: mem_done is still delivered.
- Reset mid-op:
  - Stimulus: rst asserted in MEM_BUSY.
  - Response: on the next edge all outputs are 0 and the state is IDLE; after rst is released a pending if_req is issued cleanly.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e     : arbiter FSM state encodings (ARB_IDLE, ARB_IF, ARB_MEM)
//   INST_ADDR_BUS_W : default address width (instruction address bus)
//   REG_BUS_W       : default data width (register bus)
//   mask_w()        : byte-enable width for a given data width
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_MEM  = 2'd2
    } arb_state_e;

    localparam int unsigned INST_ADDR_BUS_W = 32;
    localparam int unsigned REG_BUS_W       = 32;

    function automatic int unsigned mask_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single external memory port between instruction fetch (IF) and
// data access (MEM). MEM has fixed priority; one bus transaction at a time.
// A fetch in flight when EX signals a taken branch (flush) is discarded.
//   clk, rst                   : clock, synchronous active-high reset
//   if_req/if_addr             : fetch request (held until if_done)
//   if_data/if_done            : fetch result, one-cycle done pulse
//   mem_req/we/addr/wdata/wmask: data request (held until mem_done)
//   mem_rdata/mem_done         : load result, one-cycle done pulse
//   flush                      : taken branch/jump from EX
//   stallreq_if/stallreq_mem   : combinational stall requests
//   bus_*                      : registered bus request, bus_rdata/bus_ack in
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_BUS_W,
    parameter int unsigned DATA_W = REG_BUS_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDR_W-1:0]         if_addr,
    output logic [DATA_W-1:0]         if_data,
    output logic                      if_done,
    input  logic                      mem_req,
    input  logic                      mem_we,
    input  logic [ADDR_W-1:0]         mem_addr,
    input  logic [DATA_W-1:0]         mem_wdata,
    input  logic [mask_w(DATA_W)-1:0] mem_wmask,
    output logic [DATA_W-1:0]         mem_rdata,
    output logic                      mem_done,
    input  logic                      flush,
    output logic                      stallreq_if,
    output logic                      stallreq_mem,
    output logic                      bus_req,
    output logic                      bus_we,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_wdata,
    output logic [mask_w(DATA_W)-1:0] bus_wmask,
    input  logic [DATA_W-1:0]         bus_rdata,
    input  logic                      bus_ack
);

    localparam int unsigned MASK_W = mask_w(DATA_W);

    arb_state_e          state_q, state_d;
    logic                drop_q, drop_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [MASK_W-1:0]   bus_wmask_q, bus_wmask_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic                if_done_q, if_done_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                mem_done_q, mem_done_d;

    // A requester whose done pulse is high this cycle is being retired and
    // must not be re-issued from the request it is still holding.
    logic mem_elig, if_elig;
    assign mem_elig = mem_req & ~mem_done_q;
    assign if_elig  = if_req & ~if_done_q;

    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        if_data_d   = if_data_q;
        if_done_d   = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_done_d  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (mem_elig) begin
                    state_d     = ARB_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_wmask_d = mem_wmask;
                end else if (if_elig) begin
                    state_d     = ARB_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    bus_wmask_d = '0;
                end
            end
            ARB_IF: begin
                if (bus_ack) begin
                    state_d   = ARB_IDLE;
                    bus_req_d = 1'b0;
                    drop_d    = 1'b0;
                    // Deliver only if no flush arrived during or on the ack.
                    if (!drop_q && !flush) begin
                        if_data_d = bus_rdata;
                        if_done_d = 1'b1;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            ARB_MEM: begin
                // flush is ignored: the data access is older than the branch.
                if (bus_ack) begin
                    state_d     = ARB_IDLE;
                    bus_req_d   = 1'b0;
                    mem_rdata_d = bus_rdata;
                    mem_done_d  = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            drop_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            if_data_q   <= '0;
            if_done_q   <= 1'b0;
            mem_rdata_q <= '0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
            if_data_q   <= if_data_d;
            if_done_q   <= if_done_d;
            mem_rdata_q <= mem_rdata_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign stallreq_if  = if_req & ~if_done_q;
    assign stallreq_mem = mem_req & ~mem_done_q;

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wmask = bus_wmask_q;
    assign if_data   = if_data_q;
    assign if_done   = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;

endmodule
